// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester channels, the shared ALU port
// and the response channel. The arbiter connects through the slave modport.
// The environment (requesters, ALU, consumer) connects through the master modport.

`ifndef ALU_ARBITER_DEFINES
`define ALU_ARBITER_DEFINES
`define DSIZE 8
`define ADD   3'b000
`define SUB   3'b001
`define AND   3'b010
`define OR    3'b011
`define XOR   3'b100
`define MUL   3'b101
`define SLT   3'b110
`define PASSB 3'b111
`endif

interface alu_arbiter_if #(
  parameter int DSIZE = `DSIZE
);
  // requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [DSIZE-1:0] req0_a;
  logic [DSIZE-1:0] req0_b;
  logic [2:0]       req0_op;
  // requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [DSIZE-1:0] req1_a;
  logic [DSIZE-1:0] req1_b;
  logic [2:0]       req1_op;
  // shared ALU
  logic [DSIZE-1:0] alu_a;
  logic [DSIZE-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [DSIZE-1:0] alu_result;
  logic             alu_zero;
  // response
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [DSIZE-1:0] rsp_result;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight at a time: IDLE accepts, EXEC waits 1 cycle
// (MUL_CYCLES for MUL) for the ALU, RESP holds the result until consumed.

`ifndef ALU_ARBITER_DEFINES
`define ALU_ARBITER_DEFINES
`define DSIZE 8
`define ADD   3'b000
`define SUB   3'b001
`define AND   3'b010
`define OR    3'b011
`define XOR   3'b100
`define MUL   3'b101
`define SLT   3'b110
`define PASSB 3'b111
`endif

module alu_arbiter #(
  parameter int DSIZE      = `DSIZE,
  parameter int MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  // Out-of-range multiply latencies are pulled into 1..4 at elaboration.
  localparam int         MUL_CYC  = (MUL_CYCLES < 1) ? 1 :
                                    (MUL_CYCLES > 4) ? 4 : MUL_CYCLES;
  localparam logic [2:0] MUL_LOAD = 3'(MUL_CYC);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // control
  logic [1:0]       state_q;
  logic [2:0]       cnt_q;
  logic             last_grant_q;

  // accepted operation
  logic [DSIZE-1:0] a_q;
  logic [DSIZE-1:0] b_q;
  logic [2:0]       op_q;
  logic             id_q;

  // registered response
  logic             rsp_id_q;
  logic [DSIZE-1:0] rsp_result_q;
  logic             rsp_zero_q;

  // arbitration
  logic             grant_valid;
  logic             grant_id;
  logic [DSIZE-1:0] sel_a;
  logic [DSIZE-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             exec_done;

  // Choose which requester may hand over an operation this cycle (IDLE only).
  always_comb begin
    // NOTE: every signal written here gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == ST_IDLE) begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          // tie: the requester that did not win last time goes first
          grant_valid = 1'b1;
          grant_id    = ~last_grant_q;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end
  end

  // A grant is only ever given to a valid requester, so grant == handshake.
  assign bus.req0_ready = grant_valid & ~grant_id;
  assign bus.req1_ready = grant_valid &  grant_id;

  assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant_id ? bus.req1_op : bus.req0_op;

  // Last EXEC cycle: the ALU output for the latched operands is final.
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == 3'd1);

  // Sequence IDLE -> EXEC -> RESP -> IDLE and keep the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every block
      // sees the pre-edge values regardless of evaluation order.
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q      <= ST_EXEC;
            last_grant_q <= grant_id;
            cnt_q        <= (sel_op == `MUL) ? MUL_LOAD : 3'd1;
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q - 3'd1;
          if (exec_done) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          // leaving RESP always passes through IDLE before the next accept
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  // Latch the accepted operation; it keeps driving the ALU until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these data registers are reset on purpose: they drive the ALU
      // pins directly, which must read zero straight out of reset.
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 3'd0;
      id_q <= 1'b0;
    end else if (grant_valid) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      op_q <= sel_op;
      id_q <= grant_id;
    end
  end

  // Capture the ALU output on the last EXEC cycle and hold it through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else if (exec_done) begin
      rsp_result_q <= bus.alu_result;
      rsp_zero_q   <= bus.alu_zero;
      rsp_id_q     <= id_q;
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;

  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction/timestamp reference model.

`ifndef ALU_ARBITER_DEFINES
`define ALU_ARBITER_DEFINES
`define DSIZE 8
`define ADD   3'b000
`define SUB   3'b001
`define AND   3'b010
`define OR    3'b011
`define XOR   3'b100
`define MUL   3'b101
`define SLT   3'b110
`define PASSB 3'b111
`endif

module tb_alu_arbiter;

  localparam int DSIZE      = `DSIZE;
  localparam int MUL_CYCLES = 2;
  localparam int MUL_CYC    = (MUL_CYCLES < 1) ? 1 : (MUL_CYCLES > 4) ? 4 : MUL_CYCLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DSIZE(DSIZE)) bus ();

  alu_arbiter #(.DSIZE(DSIZE), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: drives the DUT and also gives the expected results.
  function automatic logic [DSIZE-1:0] alu_fn(input logic [DSIZE-1:0] a,
                                              input logic [DSIZE-1:0] b,
                                              input logic [2:0]       op);
    case (op)
      `ADD:    return a + b;
      `SUB:    return a - b;
      `AND:    return a & b;
      `OR:     return a | b;
      `XOR:    return a ^ b;
      `MUL:    return a * b;
      `SLT:    return (a < b) ? DSIZE'(1) : DSIZE'(0);
      default: return b;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = (bus.alu_result == '0);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one job at a time, described by timestamps.
  int               cyc = 0;
  bit               m_busy;
  int               m_rsp_cyc;
  logic             m_last;
  logic             m_id;
  logic [DSIZE-1:0] m_res;
  logic             m_zero;
  logic [DSIZE-1:0] m_a;
  logic [DSIZE-1:0] m_b;
  logic [2:0]       m_op;
  bit               hs_flag;
  logic             hs_id;
  int               grants[$];

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = 1'b1;
    m_a     = '0;
    m_b     = '0;
    m_op    = 3'd0;
    hs_flag = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit v0, input int a0, input int b0, input int o0,
                      input bit v1, input int a1, input int b1, input int o1,
                      input bit rr);
    bit e_r0, e_r1, e_rv;
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req0_a     = DSIZE'(a0);
    bus.req0_b     = DSIZE'(b0);
    bus.req0_op    = 3'(o0);
    bus.req1_valid = v1;
    bus.req1_a     = DSIZE'(a1);
    bus.req1_b     = DSIZE'(b1);
    bus.req1_op    = 3'(o1);
    bus.rsp_ready  = rr;
    #1;
    e_r0 = !m_busy && v0 && (!v1 || m_last);
    e_r1 = !m_busy && v1 && (!v0 || !m_last);
    e_rv = m_busy && (cyc >= m_rsp_cyc);
    check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    check("rsp_valid",  32'(bus.rsp_valid),  32'(e_rv));
    if (e_rv) begin
      check("rsp_id",     32'(bus.rsp_id),     32'(m_id));
      check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
      check("rsp_zero",   32'(bus.rsp_zero),   32'(m_zero));
    end
    check("alu_a",  32'(bus.alu_a),  32'(m_a));
    check("alu_b",  32'(bus.alu_b),  32'(m_b));
    check("alu_op", 32'(bus.alu_op), 32'(m_op));
    hs_flag = 1'b0;
    if (e_r0 || e_r1) begin
      hs_flag   = 1'b1;
      hs_id     = e_r1;
      m_busy    = 1'b1;
      m_last    = e_r1;
      m_id      = e_r1;
      m_a       = e_r1 ? DSIZE'(a1) : DSIZE'(a0);
      m_b       = e_r1 ? DSIZE'(b1) : DSIZE'(b0);
      m_op      = e_r1 ? 3'(o1) : 3'(o0);
      m_res     = alu_fn(m_a, m_b, m_op);
      m_zero    = (m_res == '0);
      m_rsp_cyc = cyc + 1 + ((m_op == `MUL) ? MUL_CYC : 1);
      grants.push_back(int'(e_r1));
    end else if (e_rv && rr) begin
      m_busy = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, rr);
  endtask

  // Hold one requester valid until accepted (bounded); returns accept cycle.
  task automatic issue(input bit id, input int a, input int b, input int op,
                       input bit rr, output int acc);
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      step(!id, a, b, op, id, a, b, op, rr);
      if (hs_flag) acc = cyc - 1;
    end
    if (acc < 0) check("issue_timeout", 32'(0), 32'(1));
  endtask

  // Let the current job finish with rsp_ready high (bounded).
  task automatic drain();
    for (int i = 0; i < 20 && m_busy; i++) idle(1'b1);
    check("drain_timeout", 32'(m_busy), 32'(0));
  endtask

  // Called right after a step returns, so reset lands before the next edge.
  task automatic apply_reset();
    #1;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    #1;
    check("rst_rsp_valid",  32'(bus.rsp_valid),  32'(0));
    check("rst_rsp_id",     32'(bus.rsp_id),     32'(0));
    check("rst_rsp_result", 32'(bus.rsp_result), 32'(0));
    check("rst_rsp_zero",   32'(bus.rsp_zero),   32'(0));
    check("rst_alu_a",      32'(bus.alu_a),      32'(0));
    check("rst_alu_b",      32'(bus.alu_b),      32'(0));
    check("rst_alu_op",     32'(bus.alu_op),     32'(0));
    check("rst_req0_ready", 32'(bus.req0_ready), 32'(0));
    check("rst_req1_ready", 32'(bus.req1_ready), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c0;
    logic [DSIZE-1:0] held_res;
    logic             held_id;

    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'd0;
    bus.rsp_ready  = 1'b0;
    model_reset();
    apply_reset();

    // Tie straight after reset: first cycle accepts req0, then strict alternation.
    grants.delete();
    for (int i = 0; i < 40 && grants.size() < 4; i++)
      step(1'b1, 1, 2, int'(`ADD), 1'b1, 10, 4, int'(`SUB), 1'b1);
    check("tie_count", 32'(grants.size()), 32'(4));
    for (int i = 0; i < grants.size() && i < 4; i++)
      check($sformatf("tie_order%0d", i), 32'(grants[i]), 32'(i % 2));
    drain();

    // Single ADD: accepted immediately, response two cycles later.
    c0 = cyc;
    issue(1'b0, 5, 3, int'(`ADD), 1'b1, acc);
    check("add_accept_cycle", 32'(acc), 32'(c0));
    idle(1'b1);
    check("add_c1_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    idle(1'b1);
    check("add_c2_rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("add_result",       32'(bus.rsp_result), 32'(8));
    check("add_zero",         32'(bus.rsp_zero),   32'(0));
    check("add_id",           32'(bus.rsp_id),     32'(0));
    drain();

    // MUL on req1: two EXEC cycles before the response.
    c0 = cyc;
    issue(1'b1, 6, 7, int'(`MUL), 1'b1, acc);
    check("mul_accept_cycle", 32'(acc), 32'(c0));
    idle(1'b1);
    check("mul_c1_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    idle(1'b1);
    check("mul_c2_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    idle(1'b1);
    check("mul_c3_rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("mul_result",       32'(bus.rsp_result), 32'(42));
    check("mul_id",           32'(bus.rsp_id),     32'(1));
    drain();

    // SUB producing zero.
    issue(1'b0, 9, 9, int'(`SUB), 1'b1, acc);
    idle(1'b1);
    idle(1'b1);
    check("sub_rsp_valid", 32'(bus.rsp_valid),  32'(1));
    check("sub_result",    32'(bus.rsp_result), 32'(0));
    check("sub_zero",      32'(bus.rsp_zero),   32'(1));
    drain();

    // Backpressure: hold RESP five cycles with both requesters waiting.
    issue(1'b1, 200, 100, int'(`ADD), 1'b0, acc);
    idle(1'b0);
    held_res = bus.rsp_result;
    held_id  = bus.rsp_id;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1, 1, int'(`ADD), 1'b1, 2, 2, int'(`ADD), 1'b0);
      if (i == 0) begin
        held_res = bus.rsp_result;
        held_id  = bus.rsp_id;
      end
      check("bp_rsp_valid",  32'(bus.rsp_valid),  32'(1));
      check("bp_result",     32'(bus.rsp_result), 32'(44));
      check("bp_hold_res",   32'(bus.rsp_result), 32'(held_res));
      check("bp_hold_id",    32'(bus.rsp_id),     32'(held_id));
      check("bp_req0_ready", 32'(bus.req0_ready), 32'(0));
      check("bp_req1_ready", 32'(bus.req1_ready), 32'(0));
    end
    step(1'b1, 1, 1, int'(`ADD), 1'b1, 2, 2, int'(`ADD), 1'b1);
    check("bp_release_req0_ready", 32'(bus.req0_ready), 32'(0));
    step(1'b1, 1, 1, int'(`ADD), 1'b1, 2, 2, int'(`ADD), 1'b1);
    check("bp_idle_req0_ready", 32'(bus.req0_ready), 32'(1));
    drain();

    // Reset in the middle of a MUL: no response, then req0 wins the tie.
    issue(1'b1, 3, 4, int'(`MUL), 1'b1, acc);
    idle(1'b1);
    apply_reset();
    step(1'b1, 7, 1, int'(`ADD), 1'b1, 7, 2, int'(`ADD), 1'b1);
    check("post_rst_hs",    32'(hs_flag), 32'(1));
    check("post_rst_grant", 32'(hs_id),   32'(0));
    drain();

    // Random traffic: requesters raise/drop valid and change operands freely.
    for (int n = 0; n < 2500; n++) begin
      int a0, b0, a1, b1;
      a0 = int'($urandom_range(0, (1 << DSIZE) - 1));
      b0 = ($urandom_range(0, 7) == 0) ? a0 : int'($urandom_range(0, (1 << DSIZE) - 1));
      a1 = int'($urandom_range(0, (1 << DSIZE) - 1));
      b1 = ($urandom_range(0, 7) == 0) ? a1 : int'($urandom_range(0, (1 << DSIZE) - 1));
      step($urandom_range(0, 9) < 6, a0, b0, int'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6, a1, b1, int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) apply_reset();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
